roi_capture_ctrl: RTL
=====================

Name: roi_capture_ctrl

Overview:
- Sequencer for the single-port binary ROI frame buffer (H_ACTIVE x V_ACTIVE x 1 bit).
- Arms on a start request, aligns to the next frame boundary, and writes exactly one frame of binarised pixels.
- Then owns the buffer for readout to a downstream consumer (classifier or VGA path) under ready/valid flow control.
- Capture and readout are mutually exclusive, so the buffer needs one address port only.

Parameters:
- H_ACTIVE, 320, pixels per row
- V_ACTIVE, 240, rows per frame
- GAP_THRESH, 400, consecutive iDVAL-low cycles that mark a frame boundary
- ADDR_W, 17, buffer address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE

Ports:
- iCLK  in  1  system clock
- iRST  in  1  asynchronous, active-low reset
- iStart  in  1  arm capture (level sampled per cycle)
- iAbort  in  1  return to IDLE from any state
- iDVAL  in  1  pixel valid from binariser
- iDATA  in  1  binary pixel
- iRd_req  in  1  request a full-frame readout
- iRd_ready  in  1  consumer accepts a readout beat
- iMem_q  in  1  buffer read data, 1-cycle latency after oMem_addr
- oMem_we  out  1  buffer write enable
- oMem_addr  out  ADDR_W  buffer address (write or read)
- oMem_d  out  1  buffer write data
- oRd_valid  out  1  readout beat valid
- oRd_data  out  1  readout pixel
- oRd_last  out  1  final beat of frame (with oRd_valid)
- oDone  out  1  a complete frame is held in the buffer
- oBusy  out  1  state is WAIT_FRAME, CAPTURE or READOUT
- oErr  out  1  one-cycle pulse: capture truncated by frame gap
- oPix_count  out  ADDR_W  number of 1-pixels in the last capture

Behaviour:
- Reset: state IDLE; all outputs 0; gap counter 0; addresses 0.
- Gap counter:
  - Increments on iDVAL=0 and saturates at GAP_THRESH; clears on iDVAL=1.
  - frame_edge is true while the counter equals GAP_THRESH.
- IDLE: iStart=1 -> WAIT_FRAME.
- WAIT_FRAME:
  - oDone=0. A frame_edge latches armed=1.
  - First iDVAL=1 with armed -> CAPTURE. That pixel is address 0, oPix_count is cleared, and the pixel is counted.
- CAPTURE:
  - Each iDVAL=1 cycle registers oMem_we=1, oMem_d=iDATA and oMem_addr=wr_ptr on the next cycle (1-cycle latency).
  - wr_ptr increments linearly. Row/column counters wrap the column at H_ACTIVE-1 and increment the row.
  - oPix_count += iDATA.
  - Write of address H_ACTIVE*V_ACTIVE-1 -> READY and oDone=1 (same cycle oMem_we shows the last write).
  - frame_edge before the last pixel -> oErr pulse, armed cleared, -> WAIT_FRAME. Capture then waits for the next boundary.
  - iDVAL=0 cycles below the threshold are stalls: no write and no advance.
- READY:
  - oDone=1, oMem_we=0.
  - iRd_req=1 -> READOUT with rd_ptr=0.
  - Otherwise iStart=1 -> WAIT_FRAME and oDone=0.
  - iRd_req wins over iStart in the same cycle.
- READOUT:
  - oMem_addr=rd_ptr. rd_ptr advances only in cycles where the output register is empty or iRd_ready=1 (skid-free, 1-deep pipeline plus output register).
  - oRd_valid/oRd_data are registered: data for address A appears 2 cycles after A is issued, if not stalled.
  - oRd_data/oRd_valid hold stable while oRd_valid=1 and iRd_ready=0.
  - oRd_last=1 with the beat for address H_ACTIVE*V_ACTIVE-1.
  - Accepting that beat (valid & ready) -> READY. The frame is retained and may be re-read.
  - iStart and iRd_req are ignored in READOUT.
- iAbort=1 in any state -> IDLE next cycle:
  - oRd_valid, oMem_we and oDone clear; armed clears.
  - oPix_count holds its value.
- Reset asserted mid-operation clears everything asynchronously; buffer contents are not touched.
- oMem_we is never 1 outside CAPTURE. oMem_addr carries rd_ptr in READOUT, wr_ptr otherwise.

Test Plan:
- Reset, then iStart pulse, 450 idle cycles, 76800 iDVAL=1 pixels with iDATA=1 on every 7th pixel:
  - 76800 writes at addresses 0..76799.
  - oDone=1; oPix_count=10972.
- iStart raised mid-frame (iDVAL bursts with gaps <400): no writes until a 400-cycle gap, then capture starts at address 0.
- Frame cut after 1000 pixels by a 400-cycle gap: oErr pulses once, the state returns to WAIT_FRAME, and the next full frame completes with oDone=1.
- READY, iRd_req with iRd_ready=1 constantly: 76800 beats on consecutive cycles; first oRd_valid 2 cycles after the request is accepted; oRd_last on beat 76800; return to READY.
- Readout with iRd_ready toggling at random: the beat sequence equals the written pattern exactly, with no duplicates or drops, and data stays stable during stalls.
- iAbort at pixel 5000 of capture, and separately at beat 300 of readout: IDLE next cycle with oMem_we=0, oRd_valid=0 and oDone=0.

Source files
------------

// File: rtl/roi_capture_ctrl.sv
`default_nettype none
// roi_capture_ctrl: sequencer for the single-port binary ROI frame buffer.
// Captures one gap-aligned frame, then serves it to a ready/valid consumer.
module roi_capture_ctrl #(
  parameter int H_ACTIVE   = 320,
  parameter int V_ACTIVE   = 240,
  parameter int GAP_THRESH = 400,
  parameter int ADDR_W     = 17
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iStart,
  input  logic              iAbort,
  input  logic              iDVAL,
  input  logic              iDATA,
  input  logic              iRd_req,
  input  logic              iRd_ready,
  input  logic              iMem_q,
  output logic              oMem_we,
  output logic [ADDR_W-1:0] oMem_addr,
  output logic              oMem_d,
  output logic              oRd_valid,
  output logic              oRd_data,
  output logic              oRd_last,
  output logic              oDone,
  output logic              oBusy,
  output logic              oErr,
  output logic [ADDR_W-1:0] oPix_count
);

  localparam int COL_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int ROW_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int GAP_W = $clog2(GAP_THRESH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(H_ACTIVE - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(V_ACTIVE - 1);
  localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(GAP_THRESH);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_FRAME = 3'd1,
    CAPTURE    = 3'd2,
    READY      = 3'd3,
    READOUT    = 3'd4
  } state_t;

  state_t            state, state_next;
  logic [GAP_W-1:0]  gap_cnt;
  logic              frame_edge;
  logic              armed;
  logic [ADDR_W-1:0] wr_ptr, wr_addr, cap_ptr;
  logic [COL_W-1:0]  col, col_cur;
  logic [ROW_W-1:0]  row, row_cur;
  logic              cap_wr, last_pix;
  logic              mem_we, mem_d, err, done;
  logic [ADDR_W-1:0] pix_count;
  logic [ADDR_W-1:0] rd_ptr, p1_addr;
  logic              p1_valid, p1_last, issued_all;
  logic              rd_valid, rd_data, rd_last;
  logic              rd_advance, rd_issue, rd_accept;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      gap_cnt <= '0;
    end else if (iDVAL) begin
      gap_cnt <= '0;
    end else if (gap_cnt != GAP_MAX) begin
      gap_cnt <= gap_cnt + 1'b1;
    end
  end

  assign frame_edge = (gap_cnt == GAP_MAX);

  always_comb begin
    cap_ptr = '0;
    col_cur = '0;
    row_cur = '0;
    if (state == CAPTURE) begin
      cap_ptr = wr_ptr;
      col_cur = col;
      row_cur = row;
    end
    last_pix = (col_cur == COL_LAST) && (row_cur == ROW_LAST);

    // A boundary seen in the same cycle as the first pixel still arms the capture.
    cap_wr = 1'b0;
    if (!iAbort && iDVAL) begin
      if (state == WAIT_FRAME && (armed || frame_edge)) cap_wr = 1'b1;
      if (state == CAPTURE && !frame_edge)              cap_wr = 1'b1;
    end

    rd_advance = !rd_valid || iRd_ready;
    rd_issue   = (state == READOUT) && rd_advance && !issued_all;
    rd_accept  = rd_valid && iRd_ready;

    state_next = state;
    if (iAbort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:       if (iStart) state_next = WAIT_FRAME;
        WAIT_FRAME: if (cap_wr) state_next = last_pix ? READY : CAPTURE;
        CAPTURE: begin
          if (frame_edge)              state_next = WAIT_FRAME;
          else if (cap_wr && last_pix) state_next = READY;
        end
        READY: begin
          if (iRd_req)     state_next = READOUT;
          else if (iStart) state_next = WAIT_FRAME;
        end
        READOUT:    if (rd_accept && rd_last) state_next = READY;
        default:    state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_next;
      if (state != WAIT_FRAME || iAbort) armed <= 1'b0;
      else if (frame_edge)               armed <= 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      mem_we    <= 1'b0;
      mem_d     <= 1'b0;
      wr_addr   <= '0;
      wr_ptr    <= '0;
      col       <= '0;
      row       <= '0;
      pix_count <= '0;
      err       <= 1'b0;
      done      <= 1'b0;
    end else begin
      mem_we <= cap_wr;
      err    <= (state == CAPTURE) && frame_edge && !iAbort;
      done   <= (state_next == READY) || (state_next == READOUT);
      if (cap_wr) begin
        mem_d     <= iDATA;
        wr_addr   <= cap_ptr;
        wr_ptr    <= cap_ptr + 1'b1;
        pix_count <= ((state == WAIT_FRAME) ? '0 : pix_count)
                     + {{(ADDR_W-1){1'b0}}, iDATA};
        if (col_cur == COL_LAST) begin
          col <= '0;
          row <= row_cur + 1'b1;
        end else begin
          col <= col_cur + 1'b1;
          row <= row_cur;
        end
      end
    end
  end

  // p1 tracks the read in flight; out register holds the presented beat.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      rd_ptr     <= '0;
      p1_addr    <= '0;
      p1_valid   <= 1'b0;
      p1_last    <= 1'b0;
      issued_all <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= 1'b0;
      rd_last    <= 1'b0;
    end else if (state != READOUT || iAbort) begin
      rd_ptr     <= '0;
      p1_valid   <= 1'b0;
      p1_last    <= 1'b0;
      issued_all <= 1'b0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
    end else if (rd_advance) begin
      rd_valid <= p1_valid;
      rd_data  <= iMem_q;
      rd_last  <= p1_last;
      p1_valid <= rd_issue;
      p1_last  <= rd_issue && (rd_ptr == LAST_ADDR);
      if (rd_issue) begin
        p1_addr <= rd_ptr;
        if (rd_ptr == LAST_ADDR) issued_all <= 1'b1;
        else                     rd_ptr     <= rd_ptr + 1'b1;
      end
    end
  end

  // While the output is stalled the in-flight address is re-presented so
  // iMem_q still holds that beat when the stall releases.
  always_comb begin
    oMem_addr = wr_addr;
    if (state == READOUT)
      oMem_addr = (rd_valid && !iRd_ready && p1_valid) ? p1_addr : rd_ptr;
  end

  assign oMem_we    = mem_we;
  assign oMem_d     = mem_d;
  assign oRd_valid  = rd_valid;
  assign oRd_data   = rd_data;
  assign oRd_last   = rd_last;
  assign oDone      = done;
  assign oErr       = err;
  assign oPix_count = pix_count;
  assign oBusy      = (state == WAIT_FRAME) || (state == CAPTURE) || (state == READOUT);

endmodule
`default_nettype wire
